// File: rtl/serial_read_sched.sv
// serial_read_sched: arbitrates CPU and background-poll serial word reads onto one read engine
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   SSER, BA13, BA12, BR_W  CPU bus select, address and direction, decoded to a CPU read request
//   poll_req                background poll request, level, held until poll_ack
//   SDRD                    serial data from the read engine, MSB first
//   eng_clr, eng_run        engine clear (GRANT cycle) and advance (SHIFT cycles)
//   rdata                   last completed word
//   cpu_rdy, poll_ack       one-cycle completion pulse for the CPU or poll owner
//   busy, owner             transaction in progress and its owner (0 = CPU, 1 = poll)
module serial_read_sched #(
   parameter int NBITS      = 8,
   parameter int GAP_CYC    = 2,
   parameter int STARVE_LIM = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             SSER,
   input  logic             BA13,
   input  logic             BA12,
   input  logic             BR_W,
   input  logic             poll_req,
   input  logic             SDRD,
   output logic             eng_clr,
   output logic             eng_run,
   output logic [NBITS-1:0] rdata,
   output logic             cpu_rdy,
   output logic             poll_ack,
   output logic             busy,
   output logic             owner
);
   typedef enum logic [2:0] {IDLE, GRANT, SHIFT, DONE, GAP} state_t;
   localparam logic [7:0] LIM    = 8'(STARVE_LIM);
   localparam logic [3:0] BIT_LD = 4'(NBITS - 1);
   localparam logic [3:0] GAP_LD = GAP_CYC > 0 ? 4'(GAP_CYC - 1) : 4'd0;
   localparam logic       GAP_EN = 1'(GAP_CYC > 0);
   localparam state_t     AFTER  = GAP_CYC > 0 ? GAP : IDLE;
   state_t           state;
   logic             cpu_sel_q;
   logic [3:0]       cnt;
   logic [7:0]       starve_cnt;
   logic [NBITS-1:0] sreg;
   logic [NBITS-1:0] shifted;
   logic             abort;
   logic             poll_grant;
   always_comb begin
      shifted    = {sreg[NBITS-2:0], SDRD};
      // a CPU transaction is dropped as soon as its select goes away before the word completes
      abort      = ~owner & ~cpu_sel_q & (state == GRANT || state == SHIFT);
      // poll wins when the CPU is not asking, or once it has waited long enough
      poll_grant = state == IDLE && poll_req && (!cpu_sel_q || starve_cnt >= LIM);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         cpu_sel_q  <= 1'b0;
         cnt        <= '0;
         starve_cnt <= '0;
         sreg       <= '0;
         rdata      <= '0;
         eng_clr    <= 1'b0;
         eng_run    <= 1'b0;
         cpu_rdy    <= 1'b0;
         poll_ack   <= 1'b0;
         busy       <= 1'b0;
         owner      <= 1'b0;
      end else begin
         cpu_sel_q <= ~SSER & ~BA13 & BA12 & BR_W;
         eng_clr   <= 1'b0;
         eng_run   <= 1'b0;
         cpu_rdy   <= 1'b0;
         poll_ack  <= 1'b0;
         if (poll_grant)
            starve_cnt <= '0;
         else if (poll_req && !(busy && owner) && starve_cnt < LIM)
            starve_cnt <= starve_cnt + 8'd1;
         if (abort || state == DONE) begin
            state <= AFTER;
            busy  <= GAP_EN;
            cnt   <= GAP_LD;
         end else
            case (state)
               IDLE:
                  if (cpu_sel_q || poll_req) begin
                     state   <= GRANT;
                     owner   <= poll_grant;
                     busy    <= 1'b1;
                     eng_clr <= 1'b1;
                  end
               GRANT: begin
                  state   <= SHIFT;
                  cnt     <= BIT_LD;
                  sreg    <= '0;
                  eng_run <= 1'b1;
               end
               SHIFT: begin
                  sreg <= shifted;
                  if (cnt == '0) begin
                     state    <= DONE;
                     rdata    <= shifted;
                     cpu_rdy  <= ~owner;
                     poll_ack <= owner;
                  end else begin
                     cnt     <= cnt - 4'd1;
                     eng_run <= 1'b1;
                  end
               end
               GAP:
                  if (cnt == '0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else
                     cnt <= cnt - 4'd1;
               default: state <= IDLE;
            endcase
      end
endmodule
